// File: rtl/bcd_2_digits_to_binary_converter.sv
// Two-digit BCD to 7-bit binary converter using reverse double-dabble.
// A conversion takes seven shift/correct iterations followed by a single
// DONE cycle. Optional digit validation is compiled in with the macro
// BCD_DIGIT_CHECK_EN: a digit above 9 then skips straight to DONE and
// flags digit_err. Without the macro, digit_err is tied low.
module bcd_2_digits_to_binary_converter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] bcd_val_1,
  input  logic [3:0] bcd_val_0,
  output logic [6:0] binary_val,
  output logic       busy,
  output logic       done,
  output logic       digit_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] work_q, work_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  bin_q, bin_d;

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that now reads 8 or more back down by 3.
  function automatic logic [14:0] dabble_step(input logic [14:0] w);
    logic [14:0] s;
    s = w >> 1;
    if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
    if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
    return s;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  assign bad_digit = (bcd_val_1 > 4'd9) || (bcd_val_0 > 4'd9);
`endif

  // Next-state logic: accept a request in IDLE, iterate while the counter
  // is non-zero, then publish the result on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
          if (bad_digit) begin
            state_d = DONE;
            bin_d   = 7'd0;
            work_d  = 15'd0;
            cnt_d   = 3'd0;
            err_d   = 1'b1;
          end else begin
            state_d = SHIFT;
            work_d  = {bcd_val_1, bcd_val_0, 7'b0};
            cnt_d   = 3'd7;
            err_d   = 1'b0;
          end
`else
          state_d = SHIFT;
          work_d  = {bcd_val_1, bcd_val_0, 7'b0};
          cnt_d   = 3'd7;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != 3'd0) begin
          work_d = dabble_step(work_q);
          cnt_d  = cnt_q - 3'd1;
        end else begin
          state_d = DONE;
          bin_d   = work_q[6:0];
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 15'd0;
      cnt_q   <= 3'd0;
      bin_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Remembers that the current DONE cycle came from an invalid digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign digit_err = (state_q == DONE) && err_q;
`else
  assign digit_err = 1'b0;
`endif

  assign binary_val = bin_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
